// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// master = launching controller, slave = the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell, LSB first, one bit per clock.
// Carry is kept in a flop between cycles; sum shifts in from the MSB.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [CW-1:0]     count_q, count_d;

  logic              s_bit;
  logic              c_next;

  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          count_d = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        carry_d = c_next;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        count_d = count_q + 1'b1;
        // Final bit: publish the carry-out and park the counter so it never wraps.
        if (count_q == LAST) begin
          cout_d  = c_next;
          count_d = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      count_q <= count_d;
    end
  end

  assign bus.busy = (state_q == ADD);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8) with hand-computed expectations.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one addition and follows it to its done pulse; optionally injects
  // a second start request a few cycles in, which the adder must ignore.
  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input int inject_at,
                         output int latency, output int busy_cnt);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = 8'hC3;
    bus.b     = 8'h3C;
    bus.cin   = ~cin;
    latency   = -1;
    busy_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        latency = i;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (i == inject_at) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
      end
      tick();
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.cin   = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rst       = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.sum !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_sum: got %h expected 00", bus.sum);
    end
    checks++;
    if (bus.cout !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_cout: got %b expected 0", bus.cout);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle_hold: busy got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_basic_add();
    int lat, bcnt;
    run_add(8'h5A, 8'h3C, 1'b0, -1, lat, bcnt);
    checks++;
    if (lat !== 8) begin
      errors++; $display("[TB] FAIL basic_latency: got %0d expected 8", lat);
    end
    checks++;
    if (bcnt !== 8) begin
      errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bcnt);
    end
    checks++;
    if (bus.sum !== 8'h96) begin
      errors++; $display("[TB] FAIL basic_sum: got %h expected 96", bus.sum);
    end
    checks++;
    if (bus.cout !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_cout: got %b expected 0", bus.cout);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_busy_in_done: got %b expected 0", bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_done_single: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.sum !== 8'h96) begin
      errors++; $display("[TB] FAIL basic_sum_hold: got %h expected 96", bus.sum);
    end
  endtask

  task automatic test_carry();
    int lat, bcnt;
    run_add(8'hFF, 8'h01, 1'b0, -1, lat, bcnt);
    checks++;
    if (bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
      errors++; $display("[TB] FAIL carry_ff_01: got %b_%h expected 1_00", bus.cout, bus.sum);
    end
    tick();
    run_add(8'hFF, 8'hFF, 1'b1, -1, lat, bcnt);
    checks++;
    if (bus.sum !== 8'hFF || bus.cout !== 1'b1) begin
      errors++; $display("[TB] FAIL carry_ff_ff_c1: got %b_%h expected 1_ff", bus.cout, bus.sum);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int lat, bcnt, extra;
    run_add(8'h10, 8'h20, 1'b0, 3, lat, bcnt);
    checks++;
    if (lat !== 8) begin
      errors++; $display("[TB] FAIL swb_latency: got %0d expected 8", lat);
    end
    checks++;
    if (bus.sum !== 8'h30 || bus.cout !== 1'b0) begin
      errors++; $display("[TB] FAIL swb_result: got %b_%h expected 0_30", bus.cout, bus.sum);
    end
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("[TB] FAIL swb_extra_activity: got %0d cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, seen;
    bus.a     = 8'h7F;
    bus.b     = 8'h7F;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.sum !== 8'h00 || bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_state: busy %b done %b sum %h expected 0 0 00",
                         bus.busy, bus.done, bus.sum);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", seen);
    end
    run_add(8'h01, 8'h02, 1'b0, -1, lat, bcnt);
    checks++;
    if (lat !== 8 || bus.sum !== 8'h03 || bus.cout !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_followup: lat %0d got %b_%h expected 8 0_03",
                         lat, bus.cout, bus.sum);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t1, t2, n;
    t1 = -1;
    t2 = -1;
    n  = 0;
    bus.a     = 8'h80;
    bus.b     = 8'h80;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.a   = 8'h0F;
    bus.b   = 8'hF0;
    bus.cin = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (bus.done) begin
        if (n == 0) begin
          t1 = cyc;
          checks++;
          if (bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_first: got %b_%h expected 1_00", bus.cout, bus.sum);
          end
        end else begin
          t2 = cyc;
          checks++;
          if (bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_second: got %b_%h expected 1_00", bus.cout, bus.sum);
          end
          bus.start = 1'b0;
          break;
        end
        n++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (t1 !== 8) begin
      errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected 8", t1);
    end
    checks++;
    if (t2 - t1 !== 10) begin
      errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 10", t2 - t1);
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle_after_release: busy got %b expected 0", bus.busy);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_basic_add();
    test_carry();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
